// File: rtl/sl_pkg.sv
// sl_pkg: scheduler state encoding and SL word width shared by the SL transmitter, receiver and scheduler
package sl_pkg;
  localparam int SL_WORD_W = 32;
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP} sl_state_e;
endpackage

// File: rtl/sl_tx_scheduler_if.sv
// sl_tx_scheduler_if: requester handshake and transmitter control bundle for the SL scheduler
interface sl_tx_scheduler_if
  import sl_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int GAP_W = 8
);
  logic [N_REQ-1:0]           req;
  logic [SL_WORD_W*N_REQ-1:0] req_data;
  logic [GAP_W-1:0]           gap_cycles;
  logic [N_REQ-1:0]           grant;
  logic [N_REQ-1:0]           done;
  logic                       timeout;
  logic [SL_WORD_W-1:0]       tx_data;
  logic                       tx_send;
  logic                       tx_busy;
  logic                       sched_busy;
  modport master (
    output req, req_data, gap_cycles, tx_busy,
    input  grant, done, timeout, tx_data, tx_send, sched_busy
  );
  modport slave (
    input  req, req_data, gap_cycles, tx_busy,
    output grant, done, timeout, tx_data, tx_send, sched_busy
  );
endinterface

// File: rtl/sl_rr_arbiter.sv
// sl_rr_arbiter: combinational round-robin pick, searching upward from ptr with wrap
module sl_rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         win,
  output logic [$clog2(N_REQ)-1:0] idx
);
  localparam int IW = $clog2(N_REQ);
  logic [IW-1:0] j;
  // scan farthest-first so the requester closest to ptr is the last (winning) assignment
  always_comb begin
    win = '0;
    idx = '0;
    j   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N_REQ);
      if (req[j]) begin
        win = N_REQ'(1) << j;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/sl_tx_scheduler.sv
// sl_tx_scheduler: round-robin sharing of one SL transmitter with completion/timeout tracking and idle gap
module sl_tx_scheduler
  import sl_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 8,
  parameter int GAP_W   = 8
) (
  input logic              clk,
  input logic              rst_n,
  sl_tx_scheduler_if.slave bus
);
  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT + 1);
  sl_state_e            st, nxt, gap_nxt;
  logic [IW-1:0]        ptr, ptr_d, w, w_d, idx;
  logic [TW-1:0]        tcnt, tcnt_d;
  logic [GAP_W-1:0]     gcnt, gcnt_d;
  logic [N_REQ-1:0]     win, grant_d, owner;
  logic [SL_WORD_W-1:0] data_d;
  logic                 fin;

  sl_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req(bus.req),
    .ptr(ptr),
    .win(win),
    .idx(idx)
  );

  assign owner   = N_REQ'(1) << w;
  assign fin     = !bus.tx_busy && ((st == WAIT_BUSY && tcnt == TW'(TIMEOUT)) || st == WAIT_DONE);
  assign gap_nxt = (bus.gap_cycles == '0) ? IDLE : GAP;

  // next state, arbitration capture and counter updates
  always_comb begin
    nxt     = st;
    ptr_d   = ptr;
    w_d     = w;
    grant_d = '0;
    data_d  = bus.tx_data;
    tcnt_d  = (st == WAIT_BUSY) ? tcnt + 1'b1 : '0;
    gcnt_d  = fin ? bus.gap_cycles : (gcnt != '0) ? gcnt - 1'b1 : gcnt;
    case (st)
      IDLE: if (|bus.req) begin
        nxt     = LAUNCH;
        grant_d = win;
        data_d  = bus.req_data[int'(idx)*SL_WORD_W +: SL_WORD_W];
        w_d     = idx;
        ptr_d   = (idx == IW'(N_REQ - 1)) ? '0 : idx + 1'b1;
      end
      LAUNCH:    nxt = WAIT_BUSY;
      WAIT_BUSY: nxt = bus.tx_busy ? WAIT_DONE : fin ? gap_nxt : WAIT_BUSY;
      WAIT_DONE: nxt = fin ? gap_nxt : WAIT_DONE;
      GAP:       nxt = (gcnt <= GAP_W'(1)) ? IDLE : GAP;
      default:   nxt = IDLE;
    endcase
  end

  // state, owner, pointer, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st             <= IDLE;
      ptr            <= '0;
      w              <= '0;
      tcnt           <= '0;
      gcnt           <= '0;
      bus.grant      <= '0;
      bus.done       <= '0;
      bus.timeout    <= 1'b0;
      bus.tx_send    <= 1'b0;
      bus.tx_data    <= '0;
      bus.sched_busy <= 1'b0;
    end else begin
      st             <= nxt;
      ptr            <= ptr_d;
      w              <= w_d;
      tcnt           <= tcnt_d;
      gcnt           <= gcnt_d;
      bus.grant      <= grant_d;
      bus.done       <= fin ? owner : '0;
      bus.timeout    <= fin && st == WAIT_BUSY;
      bus.tx_send    <= st == LAUNCH;
      bus.tx_data    <= data_d;
      bus.sched_busy <= nxt != IDLE;
    end
  end
endmodule

// File: doc/sl_tx_scheduler.md
# sl_tx_scheduler

Round-robin scheduler that shares one SL transmitter between `N_REQ` word sources. It accepts 32-bit words from requesters over a req/grant handshake and launches each word on the transmitter with a one-cycle send pulse. It tracks the transmitter busy flag to report per-requester completion or timeout, and enforces a programmable idle gap between words on the SL line.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT`, default 8: maximum cycles from send pulse to `tx_busy` rising.
- `GAP_W`, default 8: width of the inter-word gap count.

- `clk`  in  1  system clock, 16 MHz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  per-requester request level; held until granted.
- `req_data`  in  32*N_REQ  word from requester i in bits [32i+31:32i]; valid while `req[i]`=1.
- `gap_cycles`  in  GAP_W  idle cycles inserted after each word; sampled on entry to GAP.
- `grant`  out  N_REQ  one-hot, one-cycle pulse; the word was captured.
- `done`  out  N_REQ  one-hot, one-cycle pulse; the word finished on the line.
- `timeout`  out  1  one-cycle pulse, coincident with `done`, when the transmitter never went busy.
- `tx_data`  out  32  word presented to the transmitter; stable from `tx_send` until `done`.
- `tx_send`  out  1  one-cycle launch pulse to the transmitter.
- `tx_busy`  in  1  transmitter sending-in-process flag.
- `sched_busy`  out  1  high in every state except IDLE.

## Operation
- **States:**
  - IDLE: if any `req` is high, arbitrate, capture the winner's word, pulse `grant[w]`, and go to LAUNCH.
  - LAUNCH: `tx_send`=1 for exactly this cycle, then go to WAIT_BUSY with the timeout counter at 0.
  - WAIT_BUSY: when `tx_busy`=1, go to WAIT_DONE. Otherwise the counter increments; when it reaches `TIMEOUT`, pulse `done[w]` and `timeout`, then go to GAP.
  - WAIT_DONE: when `tx_busy` falls to 0, pulse `done[w]` and go to GAP.
  - GAP: load the counter with `gap_cycles` and count down to 0. If `gap_cycles`=0, skip GAP and go directly to IDLE.
- **Arbitration:**
  - Round robin. Search starts at the index after the last granted requester, wrapping N_REQ-1 -> 0.
  - The pointer is 0 after reset, so requester 0 has priority first.
  - The pointer updates only on grant.
- **Owner tracking:**
  - The owner index `w` is registered at grant.
  - `done` and `timeout` always refer to the owner, never to the current `req` state.
- **Requester behaviour:**
  - A requester may drop `req` before it is granted; that request is lost, with no grant and no done.
  - `req` asserted while the scheduler is not in IDLE waits for the next arbitration.
  - The granted requester must deassert `req` on the cycle after `grant`. If it does not, the request is treated as a new word at the next arbitration.
- **`tx_busy` already high when entering WAIT_BUSY:** the scheduler proceeds to WAIT_DONE immediately.
- **Reset mid-operation:** return to IDLE, all outputs at their reset values, pointer reset to 0; no done or timeout pulse is issued for the aborted word.

## Timing
- **Reset values:** `grant`=0, `done`=0, `timeout`=0, `tx_send`=0, `tx_data`=0, `sched_busy`=0.
- All outputs are registered.
- **Launch latency:** with `req[i]` high at edge t while in IDLE:
  - `grant[i]` and `tx_data` are valid after edge t.
  - `tx_send` is high after edge t+1.
- **Completion:** `done` is asserted the cycle after `tx_busy` is sampled low in WAIT_DONE.
- **Timeout:** `done` and `timeout` are asserted `TIMEOUT`+1 cycles after `tx_send`.
- **Gap:** the next `grant` comes no earlier than `gap_cycles`+1 cycles after `done`.
- **Gap counter:** `GAP_W` bits, unsigned, no wrap; it stops at 0.
- **Timeout counter:** width clog2(TIMEOUT+1).
- **Throughput:** at most one word in flight; with `gap_cycles`=0, the minimum spacing from `done` to the next `tx_send` is 2 cycles.

## Structure
- **Package `sl_pkg`:** scheduler state enum (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP) and the `SL_WORD_W`=32 constant. Shared with the SL transmitter and receiver.
- **Sub-module `sl_rr_arbiter`:** inputs are the request vector and pointer; outputs are the one-hot winner and its index. Purely combinational. The pointer register lives in the scheduler.

## Test plan
- **Single word:** `req[2]`=1 with data 32'hA5A5_0F0F; the transmitter model goes busy 2 cycles after `tx_send` and stays busy 40 cycles. Required: `grant`=4'b0100, one `tx_send` with `tx_data`=32'hA5A5_0F0F, then `done`=4'b0100 one cycle after `tx_busy` falls.
- **Fairness:** `req`=4'b1111 held, re-asserted after each grant. Required: grant order 0,1,2,3,0.
- **Timeout:** `tx_busy` held at 0, `TIMEOUT`=8. Required: `done[w]` and `timeout` pulse 9 cycles after `tx_send`, then IDLE.
- **Gap:** `gap_cycles`=5 with back-to-back requests. Required: 6 cycles from `done` to the next `grant`. With `gap_cycles`=0, 1 cycle.
- **Withdrawn request:** `req[1]` pulses while a word is in flight, then is released. Required: no `grant[1]` and no `done[1]`.
- **Reset mid-word:** `rst_n` low during WAIT_DONE. Required: all outputs 0 immediately, no done pulse, and the next request for requester 0 is granted first.
